uart_receiver: RTL and testbench

//   Serial-to-parallel UART receiver: 8 data bits, 1 start bit, 1 stop bit, no parity.

---
 rtl/uart_receiver_pkg.sv | 14 +
 rtl/uart_receiver_sync_2ff.sv | 24 ++
 rtl/uart_receiver.sv | 161 ++++++++++++++++
 tb/tb_uart_receiver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default bit timing.
package uart_receiver_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 234;  // 27 MHz / 115200 baud

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input pin; resets to 1 to match an idle-high line.
module uart_receiver_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-entry valid/ready holding register and framing/overrun pulses.
// Handshake: a byte transfers on a rising edge where valid & ready; data is stable while valid & !ready.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit LSB_FIRST    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output rx_state_t  dbg_state
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF    = CNT_W'((CLKS_PER_BIT - 1) / 2);

    logic             w_rx_s;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_deliver;
    logic             w_deliver_nxt;
    logic             r_frame_err;
    logic             w_frame_err_nxt;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_overrun;

    uart_receiver_sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_deliver   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_deliver   <= w_deliver_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_deliver_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                // A start bit that has gone high again by mid-bit is treated as line noise.
                if (r_cnt == HALF) begin
                    if (!w_rx_s) begin
                        w_cnt_nxt     = '0;
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = ST_DATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_MAX) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = LSB_FIRST ? {w_rx_s, r_shift[7:1]} : {r_shift[6:0], w_rx_s};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (r_cnt == CNT_MAX) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_deliver_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = ST_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A delivery may replace the held byte only when it is being drained in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_deliver) begin
                if (!r_valid || ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = (r_state != ST_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: one LSB-first and one MSB-first instance, scoreboarded bytes.
module tb_uart_receiver;
    import uart_receiver_pkg::*;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx_l, rx_m;
    logic       rdy_l, rdy_m;
    logic [7:0] data_l, data_m;
    logic       valid_l, valid_m;
    logic       busy_l, busy_m;
    logic       ferr_l, ferr_m;
    logic       ovr_l, ovr_m;
    rx_state_t  st_l, st_m;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid_l = 0, n_ferr_l = 0, n_ovr_l = 0;
    int n_ferr_m = 0, n_ovr_m = 0;

    logic [7:0] exp_l_q[$];
    logic [7:0] exp_m_q[$];

    uart_receiver #(.CLKS_PER_BIT(CPB), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .rx(rx_l), .data(data_l), .valid(valid_l), .ready(rdy_l),
        .busy(busy_l), .frame_err(ferr_l), .overrun(ovr_l), .dbg_state(st_l)
    );

    uart_receiver #(.CLKS_PER_BIT(CPB), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .rx(rx_m), .data(data_m), .valid(valid_m), .ready(rdy_m),
        .busy(busy_m), .frame_err(ferr_m), .overrun(ovr_m), .dbg_state(st_m)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: bytes are compared when the consumer takes them
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_l) n_valid_l++;
            if (ferr_l) n_ferr_l++;
            if (ovr_l) n_ovr_l++;
            if (ferr_m) n_ferr_m++;
            if (ovr_m) n_ovr_m++;
            if (valid_l && rdy_l) begin
                check("lsb_byte_expected", 32'(exp_l_q.size() > 0), 32'd1);
                if (exp_l_q.size() > 0) check("lsb_data", 32'(data_l), 32'(exp_l_q.pop_front()));
            end
            if (valid_m && rdy_m) begin
                check("msb_byte_expected", 32'(exp_m_q.size() > 0), 32'd1);
                if (exp_m_q.size() > 0) check("msb_data", 32'(data_m), 32'(exp_m_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_valid_l = 0; n_ferr_l = 0; n_ovr_l = 0;
        n_ferr_m = 0; n_ovr_m = 0;
    endtask

    // Drives the first n_bits of a frame (start, 8 data, stop); the line is left at the last level.
    task automatic send_frame(input bit on_msb, input logic [7:0] b, input logic stop_bit, input int n_bits);
        @(posedge clk);
        #1;
        for (int k = 0; k < n_bits; k++) begin
            logic v;
            if (k == 0) v = 1'b0;
            else if (k == 9) v = stop_bit;
            else v = on_msb ? b[8-k] : b[k-1];
            if (on_msb) rx_m = v;
            else rx_l = v;
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; rx_l = 1'b1; rx_m = 1'b1; rdy_l = 1'b1; rdy_m = 1'b1;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_data", 32'(data_l), 32'h0);
        check("rst_valid", 32'(valid_l), 32'h0);
        check("rst_busy", 32'(busy_l), 32'h0);
        check("rst_frame_err", 32'(ferr_l), 32'h0);
        check("rst_overrun", 32'(ovr_l), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);

        // 1: plain byte, consumer always ready
        clear_counts();
        exp_l_q.push_back(8'hA5);
        send_frame(1'b0, 8'hA5, 1'b1, 10);
        idle(4);
        check("t1_valid_cycles", 32'(n_valid_l), 32'd1);
        check("t1_busy_after", 32'(busy_l), 32'd0);
        check("t1_frame_err", 32'(n_ferr_l), 32'd0);
        check("t1_overrun", 32'(n_ovr_l), 32'd0);

        // 2: short low glitch
        clear_counts();
        rx_l = 1'b0;
        idle(4);
        rx_l = 1'b1;
        idle(20);
        check("t2_state_idle", 32'(st_l), 32'(ST_IDLE));
        check("t2_valid", 32'(n_valid_l), 32'd0);
        check("t2_frame_err", 32'(n_ferr_l), 32'd0);
        check("t2_overrun", 32'(n_ovr_l), 32'd0);

        // 3: framing error followed by a held-low break
        clear_counts();
        send_frame(1'b0, 8'h3C, 1'b0, 10);
        idle(40);
        check("t3_in_break", 32'(st_l), 32'(ST_BREAK));
        check("t3_busy_break", 32'(busy_l), 32'd1);
        rx_l = 1'b1;
        idle(8);
        check("t3_back_idle", 32'(st_l), 32'(ST_IDLE));
        exp_l_q.push_back(8'h55);
        send_frame(1'b0, 8'h55, 1'b1, 10);
        idle(10);
        check("t3_frame_err_pulses", 32'(n_ferr_l), 32'd1);
        check("t3_valid_cycles", 32'(n_valid_l), 32'd1);
        check("t3_overrun", 32'(n_ovr_l), 32'd0);

        // 4: overrun while holding an unread byte
        clear_counts();
        rdy_l = 1'b0;
        exp_l_q.push_back(8'h11);
        send_frame(1'b0, 8'h11, 1'b1, 10);
        idle(10);
        send_frame(1'b0, 8'h22, 1'b1, 10);
        idle(10);
        @(negedge clk);
        check("t4_overrun_pulses", 32'(n_ovr_l), 32'd1);
        check("t4_held_valid", 32'(valid_l), 32'd1);
        check("t4_held_data", 32'(data_l), 32'h11);
        check("t4_frame_err", 32'(n_ferr_l), 32'd0);
        @(posedge clk); #1;
        rdy_l = 1'b1;
        @(negedge clk); @(negedge clk);
        check("t4_valid_dropped", 32'(valid_l), 32'd0);

        // 5: drain exactly in the delivery cycle of the next byte
        clear_counts();
        idle(5);
        rdy_l = 1'b0;
        exp_l_q.push_back(8'h11);
        send_frame(1'b0, 8'h11, 1'b1, 10);
        idle(10);
        exp_l_q.push_back(8'h22);
        fork
            send_frame(1'b0, 8'h22, 1'b1, 10);
            begin
                rx_state_t prev;
                bit found;
                found = 1'b0;
                prev = st_l;
                for (int i = 0; i < 400 && !found; i++) begin
                    @(posedge clk); #1;
                    if (prev == ST_STOP && st_l == ST_IDLE) begin
                        rdy_l = 1'b1;
                        found = 1'b1;
                    end
                    prev = st_l;
                end
                check("t5_delivery_seen", 32'(found), 32'd1);
                if (found) begin
                    @(negedge clk); @(negedge clk);
                    check("t5_valid_kept", 32'(valid_l), 32'd1);
                    check("t5_new_data", 32'(data_l), 32'h22);
                    check("t5_no_overrun", 32'(ovr_l), 32'd0);
                end
            end
        join
        idle(10);
        check("t5_overrun_pulses", 32'(n_ovr_l), 32'd0);
        check("t5_drained", 32'(valid_l), 32'd0);

        // 6: reset mid-frame on the MSB-first instance, with a byte held in the other
        clear_counts();
        rdy_l = 1'b0;
        send_frame(1'b0, 8'h77, 1'b1, 10);
        idle(4);
        @(negedge clk);
        check("t6_lsb_held", 32'(data_l), 32'h77);
        send_frame(1'b1, 8'h3C, 1'b1, 5);
        @(negedge clk);
        check("t6_busy_mid_frame", 32'(busy_m), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        rx_m = 1'b1;
        idle(2);
        @(negedge clk);
        check("t6_rst_valid", 32'(valid_m), 32'd0);
        check("t6_rst_busy", 32'(busy_m), 32'd0);
        check("t6_rst_lsb_valid", 32'(valid_l), 32'd0);
        check("t6_rst_lsb_data", 32'(data_l), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_l = 1'b1;
        idle(10);
        check("t6_idle_after_rst", 32'(busy_m), 32'd0);
        exp_m_q.push_back(8'h3C);
        send_frame(1'b1, 8'h3C, 1'b1, 10);
        idle(10);
        check("t6_frame_err", 32'(n_ferr_m), 32'd0);
        check("t6_overrun", 32'(n_ovr_m), 32'd0);

        // Final report
        check("lsb_queue_empty", 32'(exp_l_q.size()), 32'd0);
        check("msb_queue_empty", 32'(exp_m_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
